tile_player_mover: RTL and testbench

//  Per-frame player position/action engine for the tile-map game; replaces the flat 400x5
//  map-bus player manager with a sequential scanner over a 1-cycle-latency map RAM read port.
//  Map size, tile size, sprite box, speed and passable/enemy tile sets are parameters.

---
 rtl/tile_player_mover.sv | 254 +++++++++++++++++++++++++
 tb/tb_tile_player_mover.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_player_mover.sv
// Per-frame player position/action engine: spawn search over the map RAM, then
// move / clamp / wall-snap / ladder / enemy-kill handling once per frame_tick.
module tile_player_mover #(
  parameter int unsigned MAP_W       = 20,
  parameter int unsigned MAP_H       = 20,
  parameter int unsigned TILE_LOG2   = 4,
  parameter int unsigned PW          = 9,
  parameter int unsigned PH          = 12,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned SPAWN_CODE  = 31,
  parameter int unsigned LADDER_CODE = 7,
  parameter logic [31:0] PASS_MASK   = 32'h80003C99,
  parameter logic [31:0] ENEMY_MASK  = 32'h00003C18,
  parameter int unsigned SCORE_INC   = 10
) (
  input  logic                               Clk,
  input  logic                               reset,
  input  logic                               frame_tick,
  input  logic [7:0]                         keycode,
  output logic [$clog2(MAP_W*MAP_H)-1:0]     map_addr,
  input  logic [4:0]                         map_data,
  output logic [9:0]                         player_x,
  output logic [9:0]                         player_y,
  output logic                               busy,
  output logic [4:0]                         collision_tile,
  output logic                               enemy_hit,
  output logic [$clog2(MAP_H)-1:0]           hit_row,
  output logic [$clog2(MAP_W)-1:0]           hit_col,
  output logic [15:0]                        score,
  output logic                               frame_overrun
);

  localparam int unsigned N   = MAP_W * MAP_H;
  localparam int unsigned AW  = $clog2(N);
  localparam int unsigned SCW = AW + 1;
  localparam int unsigned RW  = $clog2(MAP_H);
  localparam int unsigned CW  = $clog2(MAP_W);
  localparam int unsigned T   = 1 << TILE_LOG2;
  localparam logic signed [11:0] X_MAX = 12'(MAP_W * T - PW);
  localparam logic signed [11:0] Y_MAX = 12'(MAP_H * T - PH);

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_Q = 8'h14;
  localparam logic [7:0] KEY_E = 8'h08;

  typedef enum logic [2:0] {
    SPAWN, IDLE, CALC, SCAN_ADDR, SCAN_CHK, ACT_ADDR, ACT_CHK, COMMIT
  } state_t;

  state_t          state;
  logic [SCW-1:0]  spawn_cnt;
  logic [RW-1:0]   sp_row;
  logic [CW-1:0]   sp_col;
  logic            mv_l, mv_r, mv_u, mv_d, key_q, key_e;
  logic [9:0]      cand_x, cand_y;
  logic [CW-1:0]   scan_c0, scan_c1, cur_c;
  logic [RW-1:0]   scan_r1, cur_r;
  logic            ladder_pend, kill_pend;

  logic signed [11:0] raw_x, raw_y;
  logic [9:0]         cand_x_c, cand_y_c;
  logic [CW-1:0]      c0_c, c1_c, cent_c_c, nxt_c;
  logic [RW-1:0]      r0_c, r1_c, cent_r_c, nxt_r;
  logic               mv_any, last_tile_c;
  logic [11:0]        tile_x_c, tile_y_c;
  logic [16:0]        score_sum_c;

  function automatic logic [AW-1:0] tile_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * AW'(MAP_W) + AW'(c);
  endfunction

  // Candidate position, covered tile window, centre tile and scan sequencing.
  always_comb begin
    mv_any = mv_l | mv_r | mv_u | mv_d;
    raw_x  = $signed({2'b00, player_x});
    raw_y  = $signed({2'b00, player_y});
    if (mv_r) raw_x = raw_x + 12'(SPEED);
    if (mv_l) raw_x = raw_x - 12'(SPEED);
    if (mv_d) raw_y = raw_y + 12'(SPEED);
    if (mv_u) raw_y = raw_y - 12'(SPEED);

    if (raw_x[11])          cand_x_c = '0;
    else if (raw_x > X_MAX) cand_x_c = 10'(X_MAX);
    else                    cand_x_c = raw_x[9:0];
    if (raw_y[11])          cand_y_c = '0;
    else if (raw_y > Y_MAX) cand_y_c = 10'(Y_MAX);
    else                    cand_y_c = raw_y[9:0];

    c0_c = CW'(cand_x_c >> TILE_LOG2);
    c1_c = CW'((cand_x_c + 10'(PW - 1)) >> TILE_LOG2);
    r0_c = RW'(cand_y_c >> TILE_LOG2);
    r1_c = RW'((cand_y_c + 10'(PH - 1)) >> TILE_LOG2);

    cent_c_c = CW'((player_x + 10'(PW / 2)) >> TILE_LOG2);
    cent_r_c = RW'((player_y + 10'(PH / 2)) >> TILE_LOG2);

    last_tile_c = (cur_c == scan_c1) && (cur_r == scan_r1);
    nxt_c = cur_c;
    nxt_r = cur_r;
    if (cur_c != scan_c1) begin
      nxt_c = cur_c + 1'b1;
    end else begin
      nxt_c = scan_c0;
      nxt_r = cur_r + 1'b1;
    end

    tile_x_c    = 12'(cur_c) << TILE_LOG2;
    tile_y_c    = 12'(cur_r) << TILE_LOG2;
    score_sum_c = {1'b0, score} + 17'(SCORE_INC);
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state          <= SPAWN;
      spawn_cnt      <= '0;
      sp_row         <= '0;
      sp_col         <= '0;
      map_addr       <= '0;
      player_x       <= '0;
      player_y       <= '0;
      busy           <= 1'b0;
      collision_tile <= '0;
      enemy_hit      <= 1'b0;
      hit_row        <= '0;
      hit_col        <= '0;
      score          <= '0;
      frame_overrun  <= 1'b0;
      mv_l           <= 1'b0;
      mv_r           <= 1'b0;
      mv_u           <= 1'b0;
      mv_d           <= 1'b0;
      key_q          <= 1'b0;
      key_e          <= 1'b0;
      cand_x         <= '0;
      cand_y         <= '0;
      scan_c0        <= '0;
      scan_c1        <= '0;
      scan_r1        <= '0;
      cur_c          <= '0;
      cur_r          <= '0;
      ladder_pend    <= 1'b0;
      kill_pend      <= 1'b0;
    end else begin
      enemy_hit <= 1'b0;
      if (frame_tick && state != IDLE && state != SPAWN) frame_overrun <= 1'b1;

      case (state)
        // Streamed read: the data seen now belongs to the address issued last cycle.
        SPAWN: begin
          busy <= 1'b1;
          if (spawn_cnt != '0) begin
            if (map_data == 5'(SPAWN_CODE)) begin
              player_x <= 10'(sp_col) << TILE_LOG2;
              player_y <= 10'(sp_row) << TILE_LOG2;
            end
            if (sp_col == CW'(MAP_W - 1)) begin
              sp_col <= '0;
              sp_row <= sp_row + 1'b1;
            end else begin
              sp_col <= sp_col + 1'b1;
            end
          end
          if (spawn_cnt == SCW'(N)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            spawn_cnt <= spawn_cnt + 1'b1;
            if (spawn_cnt < SCW'(N - 1)) map_addr <= AW'(spawn_cnt + 1'b1);
          end
        end

        IDLE: begin
          if (frame_tick) begin
            mv_l  <= (keycode == KEY_A);
            mv_r  <= (keycode == KEY_D);
            mv_d  <= (keycode == KEY_S);
            mv_u  <= (keycode == KEY_W);
            key_q <= (keycode == KEY_Q);
            key_e <= (keycode == KEY_E);
            busy  <= 1'b1;
            state <= CALC;
          end
        end

        CALC: begin
          cand_x <= cand_x_c;
          cand_y <= cand_y_c;
          if (mv_any) begin
            scan_c0  <= c0_c;
            scan_c1  <= c1_c;
            scan_r1  <= r1_c;
            cur_c    <= c0_c;
            cur_r    <= r0_c;
            map_addr <= tile_addr(r0_c, c0_c);
            state    <= SCAN_ADDR;
          end else begin
            map_addr <= tile_addr(cent_r_c, cent_c_c);
            state    <= ACT_ADDR;
          end
        end

        SCAN_ADDR: state <= SCAN_CHK;

        // First blocking tile snaps the box flush against it on the moving axis.
        SCAN_CHK: begin
          if (!PASS_MASK[map_data]) begin
            if (mv_r)      cand_x <= (tile_x_c >= 12'(PW)) ? 10'(tile_x_c - 12'(PW)) : '0;
            else if (mv_l) cand_x <= 10'(tile_x_c + 12'(T));
            else if (mv_d) cand_y <= (tile_y_c >= 12'(PH)) ? 10'(tile_y_c - 12'(PH)) : '0;
            else if (mv_u) cand_y <= 10'(tile_y_c + 12'(T));
            map_addr <= tile_addr(cent_r_c, cent_c_c);
            state    <= ACT_ADDR;
          end else if (last_tile_c) begin
            map_addr <= tile_addr(cent_r_c, cent_c_c);
            state    <= ACT_ADDR;
          end else begin
            cur_c    <= nxt_c;
            cur_r    <= nxt_r;
            map_addr <= tile_addr(nxt_r, nxt_c);
            state    <= SCAN_ADDR;
          end
        end

        ACT_ADDR: state <= ACT_CHK;

        ACT_CHK: begin
          ladder_pend <= (map_data == 5'(LADDER_CODE)) && key_q;
          kill_pend   <= ENEMY_MASK[map_data] && key_e;
          state       <= COMMIT;
        end

        COMMIT: begin
          player_x       <= cand_x;
          player_y       <= cand_y;
          collision_tile <= ladder_pend ? 5'(LADDER_CODE) : 5'd0;
          if (kill_pend) begin
            enemy_hit <= 1'b1;
            hit_row   <= cent_r_c;
            hit_col   <= cent_c_c;
            score     <= score_sum_c[16] ? 16'hFFFF : score_sum_c[15:0];
          end
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_player_mover.sv
// Directed bench for tile_player_mover with a 1-cycle-latency map RAM model.
module tb_tile_player_mover;

  logic       Clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [7:0] keycode;
  logic [8:0] map_addr;
  logic [4:0] map_data;
  logic [9:0] player_x, player_y;
  logic       busy;
  logic [4:0] collision_tile;
  logic       enemy_hit;
  logic [4:0] hit_row, hit_col;
  logic [15:0] score;
  logic       frame_overrun;

  logic [4:0] mem [0:511];
  int checks = 0;
  int errors = 0;
  int cycles;
  int hit_cnt;

  localparam logic [7:0] K_A = 8'h04, K_D = 8'h07, K_S = 8'h16, K_W = 8'h1A;
  localparam logic [7:0] K_Q = 8'h14, K_E = 8'h08, K_NONE = 8'h00;

  tile_player_mover dut (
    .Clk(Clk), .reset(reset), .frame_tick(frame_tick), .keycode(keycode),
    .map_addr(map_addr), .map_data(map_data), .player_x(player_x), .player_y(player_y),
    .busy(busy), .collision_tile(collision_tile), .enemy_hit(enemy_hit),
    .hit_row(hit_row), .hit_col(hit_col), .score(score), .frame_overrun(frame_overrun)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) map_data <= mem[map_addr];

  function automatic int idx(input int r, input int c);
    return r * 20 + c;
  endfunction

  // Pulse frame_tick from a negedge and wait (bounded) for the frame to finish.
  task automatic do_frame(input logic [7:0] key);
    keycode    = key;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    cycles  = 1;
    hit_cnt = 0;
    while (busy && cycles < 40) begin
      if (enemy_hit) hit_cnt++;
      @(negedge Clk);
      cycles++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_done: busy=%b after %0d cycles, required 0", busy, cycles);
    end
    if (enemy_hit) hit_cnt++;
    @(negedge Clk);
    if (enemy_hit) hit_cnt++;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge Clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge Clk);
    checks++;
    if ({player_x, player_y, busy, collision_tile, enemy_hit, hit_row, hit_col, score, frame_overrun, map_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: x=%0d y=%0d busy=%b score=%0d addr=%0d, required all 0", player_x, player_y, busy, score, map_addr);
    end
    reset = 1'b0;
    @(negedge Clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL spawn_busy: got %b, expected 1", busy); end
    wait_idle(1000);
    checks++;
    if (busy !== 1'b0 || player_x !== 10'd48 || player_y !== 10'd32) begin
      errors++;
      $display("FAIL spawn_pos: busy=%b x=%0d y=%0d, expected busy=0 x=48 y=32", busy, player_x, player_y);
    end
  endtask

  task automatic test_free_move;
    do_frame(K_D);
    checks++;
    if (player_x !== 10'd50 || player_y !== 10'd32) begin
      errors++; $display("FAIL move_d1: x=%0d y=%0d, expected 50 32", player_x, player_y);
    end
    checks++;
    if (cycles > 13) begin errors++; $display("FAIL latency: got %0d cycles, expected <= 13", cycles); end
    do_frame(K_D);
    do_frame(K_D);
    checks++;
    if (player_x !== 10'd54 || player_y !== 10'd32) begin
      errors++; $display("FAIL move_d3: x=%0d y=%0d, expected 54 32", player_x, player_y);
    end
  endtask

  task automatic test_wall_snap;
    mem[idx(2, 4)] = 5'd1;
    do_frame(K_D);
    checks++;
    if (player_x !== 10'd55 || player_y !== 10'd32) begin
      errors++; $display("FAIL snap_px: x=%0d y=%0d, expected 55 32", player_x, player_y);
    end
    do_frame(K_D);
    checks++;
    if (player_x !== 10'd55) begin errors++; $display("FAIL snap_px_again: x=%0d, expected 55", player_x); end
    mem[idx(3, 3)] = 5'd2;
    do_frame(K_S);
    do_frame(K_S);
    checks++;
    if (player_y !== 10'd36) begin errors++; $display("FAIL move_s2: y=%0d, expected 36", player_y); end
    do_frame(K_S);
    checks++;
    if (player_y !== 10'd36 || player_x !== 10'd55) begin
      errors++; $display("FAIL snap_py: x=%0d y=%0d, expected 55 36", player_x, player_y);
    end
    do_frame(K_A);
    checks++;
    if (player_x !== 10'd53 || player_y !== 10'd36) begin
      errors++; $display("FAIL move_a: x=%0d y=%0d, expected 53 36", player_x, player_y);
    end
  endtask

  task automatic test_ladder;
    mem[idx(2, 3)] = 5'd7;
    do_frame(K_Q);
    checks++;
    if (collision_tile !== 5'd7 || player_x !== 10'd53 || player_y !== 10'd36) begin
      errors++; $display("FAIL ladder_q: tile=%0d x=%0d y=%0d, expected 7 53 36", collision_tile, player_x, player_y);
    end
    do_frame(K_NONE);
    checks++;
    if (collision_tile !== 5'd0) begin errors++; $display("FAIL ladder_clear: tile=%0d, expected 0", collision_tile); end
  endtask

  task automatic test_kill;
    mem[idx(2, 3)] = 5'd10;
    do_frame(K_E);
    checks++;
    if (hit_cnt !== 1 || hit_row !== 5'd2 || hit_col !== 5'd3 || score !== 16'd10) begin
      errors++;
      $display("FAIL kill: pulses=%0d row=%0d col=%0d score=%0d, expected 1 2 3 10", hit_cnt, hit_row, hit_col, score);
    end
    mem[idx(2, 3)] = 5'd0;
    do_frame(K_E);
    checks++;
    if (hit_cnt !== 0 || score !== 16'd10 || hit_row !== 5'd2 || hit_col !== 5'd3) begin
      errors++; $display("FAIL no_kill: pulses=%0d score=%0d row=%0d col=%0d, expected 0 10 2 3", hit_cnt, score, hit_row, hit_col);
    end
    mem[idx(2, 3)] = 5'd11;
    do_frame(K_Q);
    checks++;
    if (hit_cnt !== 0 || score !== 16'd10 || collision_tile !== 5'd0) begin
      errors++; $display("FAIL q_on_enemy: pulses=%0d score=%0d tile=%0d, expected 0 10 0", hit_cnt, score, collision_tile);
    end
  endtask

  task automatic test_score_sat;
    for (int i = 0; i < 6552; i++) do_frame(K_E);
    checks++;
    if (score !== 16'hFFFA) begin errors++; $display("FAIL score_near_max: got %h, expected fffa", score); end
    do_frame(K_E);
    checks++;
    if (score !== 16'hFFFF || hit_cnt !== 1) begin
      errors++; $display("FAIL score_sat: score=%h pulses=%0d, expected ffff 1", score, hit_cnt);
    end
    do_frame(K_E);
    checks++;
    if (score !== 16'hFFFF) begin errors++; $display("FAIL score_hold: got %h, expected ffff", score); end
  endtask

  task automatic test_back_to_back;
    checks++;
    if (frame_overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b, expected 0", frame_overrun); end
    mem[idx(2, 3)] = 5'd0;
    keycode    = K_D;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    @(negedge Clk);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    wait_idle(40);
    repeat (3) @(negedge Clk);
    checks++;
    if (frame_overrun !== 1'b1) begin errors++; $display("FAIL overrun: got %b, expected 1", frame_overrun); end
    checks++;
    if (busy !== 1'b0 || player_x !== 10'd55 || player_y !== 10'd36) begin
      errors++; $display("FAIL dropped_tick: busy=%b x=%0d y=%0d, expected 0 55 36", busy, player_x, player_y);
    end
  endtask

  task automatic test_reset_mid_scan;
    mem[idx(0, 1)] = 5'd0;
    mem[idx(2, 3)] = 5'd0;
    keycode    = K_S;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge Clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({player_x, player_y, busy, collision_tile, enemy_hit, hit_row, hit_col, score, frame_overrun, map_addr} !== '0) begin
      errors++;
      $display("FAIL reset_mid_scan: x=%0d y=%0d busy=%b score=%h ovr=%b addr=%0d, required all 0", player_x, player_y, busy, score, frame_overrun, map_addr);
    end
    @(negedge Clk);
    reset = 1'b0;
    repeat (3) @(negedge Clk);
    keycode    = K_D;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rescan_busy: got %b, expected 1", busy); end
    wait_idle(1000);
    checks++;
    if (busy !== 1'b0 || frame_overrun !== 1'b0 || player_x !== 10'd0 || player_y !== 10'd0) begin
      errors++; $display("FAIL rescan: busy=%b ovr=%b x=%0d y=%0d, expected 0 0 0 0", busy, frame_overrun, player_x, player_y);
    end
  endtask

  task automatic test_edge_clamp;
    do_frame(K_A);
    checks++;
    if (player_x !== 10'd0 || player_y !== 10'd0) begin
      errors++; $display("FAIL clamp_a: x=%0d y=%0d, expected 0 0", player_x, player_y);
    end
    do_frame(K_W);
    checks++;
    if (player_x !== 10'd0 || player_y !== 10'd0) begin
      errors++; $display("FAIL clamp_w: x=%0d y=%0d, expected 0 0", player_x, player_y);
    end
    do_frame(K_S);
    checks++;
    if (player_x !== 10'd0 || player_y !== 10'd2) begin
      errors++; $display("FAIL move_s_from_edge: x=%0d y=%0d, expected 0 2", player_x, player_y);
    end
  endtask

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    keycode    = 8'h00;
    for (int i = 0; i < 512; i++) mem[i] = 5'd0;
    mem[idx(0, 1)] = 5'd31;
    mem[idx(2, 3)] = 5'd31;
    test_reset;
    test_free_move;
    test_wall_snap;
    test_ladder;
    test_kill;
    test_score_sat;
    test_back_to_back;
    test_reset_mid_scan;
    test_edge_clamp;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
